// File: rtl/fixed_point_div_if.sv
// Request/response bundle for fixed_point_div: the master raises a division
// request, the slave returns the registered quotient, status flags and handshake.
interface fixed_point_div_if #(
  parameter int W = 16
);
  logic         start;
  logic         sign;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         busy;
  logic         done;
  logic         overflow;
  logic         underflow;
  logic         div_by_zero;

  modport master (
    output start, sign, a, b,
    input  result, busy, done, overflow, underflow, div_by_zero
  );

  modport slave (
    input  start, sign, a, b,
    output result, busy, done, overflow, underflow, div_by_zero
  );
endinterface

// File: rtl/fixed_point_div.sv
// Multi-cycle restoring divider for Q(I_P).(F_P) operands, signed or unsigned per request.
// Define FIXED_POINT_DIV_ROUND_EN to add a guard bit and round half away from zero.
module fixed_point_div #(
  parameter int I_P = 2,
  parameter int F_P = 14
) (
  input logic              clk,
  input logic              rst_n,
  fixed_point_div_if.slave bus
);
  localparam int W = I_P + F_P;
`ifdef FIXED_POINT_DIV_ROUND_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif
  localparam int N  = W + F_P + G;
  localparam int MW = W + F_P + 1;
  localparam int CW = $clog2(N + 2);

  localparam logic [CW-1:0] LAST    = CW'(N);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  ONE_W   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  MAX_U   = {W{1'b1}};
  localparam logic [W-1:0]  MAX_S   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MIN_S   = {1'b1, {(W-1){1'b0}}};
  localparam logic [MW-1:0] LIM_U   = {{(MW-W-1){1'b0}}, 1'b1, {W{1'b0}}};
  localparam logic [MW-1:0] LIM_S   = {{(MW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_sign, r_qs, r_a_zero, r_b_zero;
  logic [W-1:0]  r_b_mag;
  logic [W-1:0]  r_rem;
  logic [N-1:0]  r_dvd;
  logic [N-1:0]  r_q;
  logic [MW-1:0] r_mag;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_result;
  logic          r_busy, r_done, r_ovf, r_unf, r_dbz;

  logic          w_accept;
  logic [W-1:0]  w_a_mag, w_b_mag;
  logic [W:0]    w_trial;
  logic [W-1:0]  w_sub;
  logic          w_ge;
  logic [MW-1:0] w_mag_fin;
  logic [W-1:0]  w_res;
  logic          w_ovf, w_unf;

  function automatic logic [W-1:0] mag_of(input logic [W-1:0] v, input logic s);
    logic [W-1:0] m;
    if (s && v[W-1]) m = ~v + ONE_W;
    else             m = v;
    return m;
  endfunction

  // A request arriving while the done pulse is high is deliberately dropped.
  assign w_accept = (r_state == IDLE) && bus.start && !r_done;
  assign w_a_mag  = mag_of(bus.a, bus.sign);
  assign w_b_mag  = mag_of(bus.b, bus.sign);
  assign w_trial  = {r_rem, r_dvd[N-1]};
  assign w_ge     = (w_trial >= {1'b0, r_b_mag});
  assign w_sub    = w_trial[W-1:0] - r_b_mag;

`ifdef FIXED_POINT_DIV_ROUND_EN
  assign w_mag_fin = {1'b0, r_q[N-1:1]} + {{(MW-1){1'b0}}, r_q[0]};
`else
  assign w_mag_fin = {1'b0, r_q};
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: N iterations plus one rounding cycle in CALC, then FIX
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = CALC; else w_next = IDLE;
      CALC: if (r_cnt == LAST) w_next = FIX; else w_next = CALC;
      FIX:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture and one restoring-division step per CALC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign   <= 1'b0;
      r_qs     <= 1'b0;
      r_a_zero <= 1'b0;
      r_b_zero <= 1'b0;
      r_b_mag  <= {W{1'b0}};
      r_rem    <= {W{1'b0}};
      r_dvd    <= {N{1'b0}};
      r_q      <= {N{1'b0}};
      r_mag    <= {MW{1'b0}};
      r_cnt    <= {CW{1'b0}};
    end else if (w_accept) begin
      r_sign   <= bus.sign;
      r_qs     <= bus.sign & (bus.a[W-1] ^ bus.b[W-1]);
      r_a_zero <= (bus.a == {W{1'b0}});
      r_b_zero <= (bus.b == {W{1'b0}});
      r_b_mag  <= w_b_mag;
      r_rem    <= {W{1'b0}};
      r_dvd    <= {w_a_mag, {(F_P+G){1'b0}}};
      r_q      <= {N{1'b0}};
      r_cnt    <= {CW{1'b0}};
    end else if (r_state == CALC) begin
      if (r_cnt == LAST) begin
        r_mag <= w_mag_fin;
      end else begin
        r_rem <= w_ge ? w_sub : w_trial[W-1:0];
        r_dvd <= {r_dvd[N-2:0], 1'b0};
        r_q   <= {r_q[N-2:0], w_ge};
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  // Range check, saturation and sign application of the final magnitude
  always_comb begin
    w_res = {W{1'b0}};
    w_ovf = 1'b0;
    w_unf = 1'b0;
    if (r_b_zero) begin
      w_ovf = 1'b1;
      if (!r_sign)   w_res = MAX_U;
      else if (r_qs) w_res = MIN_S;
      else           w_res = MAX_S;
    end else if (!r_sign) begin
      if (r_mag >= LIM_U) begin w_ovf = 1'b1; w_res = MAX_U; end
      else                w_res = r_mag[W-1:0];
    end else if (!r_qs) begin
      if (r_mag >= LIM_S) begin w_ovf = 1'b1; w_res = MAX_S; end
      else                w_res = r_mag[W-1:0];
    end else begin
      if (r_mag > LIM_S) begin w_ovf = 1'b1; w_res = MIN_S; end
      else               w_res = ~r_mag[W-1:0] + ONE_W;
    end
    if (!r_b_zero && !r_a_zero && !w_ovf && (r_mag == {MW{1'b0}})) begin
      w_unf = 1'b1;
      w_res = r_qs ? MAX_U : ONE_W;
    end else begin
      w_unf = 1'b0;
    end
  end

  // Registered outputs: results load on leaving FIX and hold until the next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= {W{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_dbz    <= 1'b0;
    end else if (w_accept) begin
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_state == FIX) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b1;
      r_result <= w_res;
      r_ovf    <= w_ovf;
      r_unf    <= w_unf;
      r_dbz    <= r_b_zero;
    end else begin
      r_done <= 1'b0;
    end
  end

  assign bus.result      = r_result;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.overflow    = r_ovf;
  assign bus.underflow   = r_unf;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_fixed_point_div.sv
// Self-checking bench for fixed_point_div: directed vector table, multi-cycle
// corner sequences and random operations against an integer-arithmetic model.
module tb_fixed_point_div;
  localparam int I_P = 2;
  localparam int F_P = 14;
  localparam int W   = I_P + F_P;
`ifdef FIXED_POINT_DIV_ROUND_EN
  localparam int LAT = W + F_P + 1 + 2;
  localparam bit RND = 1'b1;
`else
  localparam int LAT = W + F_P + 2;
  localparam bit RND = 1'b0;
`endif

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ovf;
    logic         unf;
    logic         dbz;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[$];

  fixed_point_div_if #(.W(W)) bus ();

  fixed_point_div #(.I_P(I_P), .F_P(F_P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain integer division of the real values, then range rules. Returns {dbz,ovf,unf,res}.
  function automatic logic [W+2:0] ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint av, bv, aa, bb, mag, half;
    logic neg, ovf, unf, dbz;
    logic [W-1:0] res;
    av   = (s && a[W-1]) ? longint'(a) - (longint'(1) << W) : longint'(a);
    bv   = (s && b[W-1]) ? longint'(b) - (longint'(1) << W) : longint'(b);
    neg  = s && ((av < 0) != (bv < 0));
    aa   = (av < 0) ? -av : av;
    bb   = (bv < 0) ? -bv : bv;
    half = longint'(1) << (W - 1);
    dbz  = (bb == 0);
    unf  = 1'b0;
    if (dbz)      mag = longint'(1) << 40;
    else if (RND) mag = ((aa << (F_P + 1)) + bb) / (2 * bb);
    else          mag = (aa << F_P) / bb;
    if (!s) begin
      ovf = (mag >= (longint'(1) << W));
      res = ovf ? W'((longint'(1) << W) - 1) : W'(mag);
    end else if (!neg) begin
      ovf = (mag >= half);
      res = ovf ? W'(half - 1) : W'(mag);
    end else begin
      ovf = (mag > half);
      res = ovf ? W'(half) : W'(-mag);
    end
    if (!dbz && aa != 0 && !ovf && mag == 0) begin
      unf = 1'b1;
      res = neg ? W'(-1) : W'(1);
    end
    return {dbz, ovf, unf, res};
  endfunction

  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W+2:0] exp, input string tag);
    int   lat;
    logic busy1;
    @(negedge clk);
    bus.start = 1'b1; bus.sign = s; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.sign = ~s; bus.a = ~a; bus.b = ~b;
    busy1 = bus.busy;
    lat = -1;
    for (int k = 1; k <= LAT + 8; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = k; break; end
    end
    check($sformatf("%s busy", tag), {31'd0, busy1}, 32'd1);
    check($sformatf("%s latency", tag), lat, LAT);
    check($sformatf("%s result", tag), {16'd0, bus.result}, {16'd0, exp[W-1:0]});
    check($sformatf("%s flags(dbz,ovf,unf)", tag),
          {29'd0, bus.div_by_zero, bus.overflow, bus.underflow}, {29'd0, exp[W+2:W]});
    @(posedge clk); #1;
    check($sformatf("%s done width", tag), {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int   lat;
    logic seen;
    logic [W-1:0] ra, rb;
    logic rs;

    tbl.push_back('{1'b1, 16'h2000, 16'h4000, 16'h2000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 16'h4000, 16'h2000, 16'h7FFF, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 16'hC000, 16'h2000, 16'h8000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 16'h0001, 16'h7FFF, 16'h0001, 1'b0, !RND, 1'b0});
    tbl.push_back('{1'b1, 16'hC000, 16'h0000, 16'h8000, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 16'h4000, 16'h8000, 16'h2000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 16'hFFFF, 16'h7FFF, 16'hFFFF, 1'b0, !RND, 1'b0});
    tbl.push_back('{1'b0, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 16'hC000, 16'h1000, 16'h8000, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 16'h8000, 16'hC000, 16'h7FFF, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 16'h6000, 16'h4000, 16'h6000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 16'hC000, 16'h3000, 16'hAAAB, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 16'h2000, 16'h3000, RND ? 16'h2AAB : 16'h2AAA, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0001, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 16'hC000, 16'h4000, 16'hC000, 1'b0, 1'b0, 1'b0});

    bus.start = 1'b0; bus.sign = 1'b0; bus.a = 16'h0000; bus.b = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {11'd0, bus.result, bus.busy, bus.done, bus.overflow,
          bus.underflow, bus.div_by_zero}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i])
      run_op(tbl[i].s, tbl[i].a, tbl[i].b,
             {tbl[i].dbz, tbl[i].ovf, tbl[i].unf, tbl[i].res}, $sformatf("vec%0d", i));

    // start held high throughout a busy operation with changing operands
    @(negedge clk);
    bus.start = 1'b1; bus.sign = 1'b1; bus.a = 16'h2000; bus.b = 16'h4000;
    @(posedge clk); #1;
    lat = -1;
    for (int k = 1; k <= LAT + 8; k++) begin
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.sign = 1'($urandom);
      @(posedge clk); #1;
      if (bus.done) begin lat = k; break; end
    end
    check("hold latency", lat, LAT);
    check("hold result", {16'd0, bus.result}, 32'h0000_2000);
    check("hold flags", {29'd0, bus.div_by_zero, bus.overflow, bus.underflow}, 32'd0);
    @(posedge clk); #1;
    check("start during done ignored", {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b0;

    // reset in the middle of a calculation
    @(negedge clk);
    bus.start = 1'b1; bus.sign = 1'b1; bus.a = 16'h4000; bus.b = 16'h3000;
    @(posedge clk); #1;
    for (int k = 1; k < 10; k++) begin
      bus.a = 16'($urandom); bus.b = 16'($urandom);
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst_n = 1'b0; bus.start = 1'b0;
    #1;
    check("mid reset outputs", {11'd0, bus.result, bus.busy, bus.done, bus.overflow,
          bus.underflow, bus.div_by_zero}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < LAT + 5; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check("no activity after reset", {31'd0, seen}, 32'd0);
    run_op(1'b1, 16'h4000, 16'h3000, ref_div(1'b1, 16'h4000, 16'h3000), "post-reset");

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 16'h0000;
        1:       rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      run_op(rs, ra, rb, ref_div(rs, ra, rb), $sformatf("rand%0d s=%0d a=%h b=%h", i, rs, ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
